// File: rtl/gray_rgb_pkg.sv
// Shared definitions for the grayscale-to-RGB565 expand custom instruction:
// opcodes, FSM state type and RGB565 field widths.
package gray_rgb_pkg;

    localparam logic [7:0] ISE_ID_DEFAULT = 8'h0C;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_NEXT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam int RED_W   = 5;
    localparam int GREEN_W = 6;
    localparam int BLUE_W  = 5;
    localparam int PIXEL_W = RED_W + GREEN_W + BLUE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gray_rgb565_pixel.sv
// One gray byte plus a saturating brightness offset, replicated into the
// three RGB565 channels by keeping the top bits of the adjusted gray level.
module gray_rgb565_pixel
    import gray_rgb_pkg::*;
(
    input  logic [7:0]         gray,
    input  logic [7:0]         offset,
    output logic [PIXEL_W-1:0] pixel
);

    logic [8:0] sum;
    logic [7:0] level;
    logic       unused_low;

    assign sum   = {1'b0, gray} + {1'b0, offset};
    assign level = sum[8] ? 8'hFF : sum[7:0];
    assign pixel = {level[7 -: RED_W], level[7 -: GREEN_W], level[7 -: BLUE_W]};

    // The two lowest gray bits never reach any channel.
    assign unused_low = ^level[1:0];

endmodule

// File: rtl/gray_rgb565_expand_ise.sv
// Custom instruction: LOAD expands four gray bytes to RGB565, returning the
// low pair and buffering the high pair for a later NEXT; CLEAR drops it.
module gray_rgb565_expand_ise
    import gray_rgb_pkg::*;
#(
    parameter logic [7:0] customInstructionId = ISE_ID_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    // Handshake: an instruction is taken when start is high with a matching
    // id in IDLE; done is a one-cycle pulse and result is zero outside it.
    state_t       state_q, state_d;
    logic         accept;
    logic [1:0]   op_q;
    logic [31:0]  data_q;
    logic [7:0]   offset_q;
    logic [31:0]  buffer_q;
    logic         pending_q;
    logic [31:0]  result_q;
    logic [PIXEL_W-1:0] pix [4];
    logic         unused_b;

    assign unused_b = ^{valueB[31:16], valueB[7:2]};
    assign accept   = start && (iseId == customInstructionId) && (state_q == ST_IDLE);

    for (genvar i = 0; i < 4; i++) begin : g_pix
        gray_rgb565_pixel u_pixel (
            .gray   (data_q[8*i +: 8]),
            .offset (offset_q),
            .pixel  (pix[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'd0;
            data_q    <= 32'd0;
            offset_q  <= 8'd0;
            buffer_q  <= 32'd0;
            pending_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= valueB[1:0];
                data_q   <= valueA;
                offset_q <= valueB[15:8];
            end
            if (state_q == ST_CALC) begin
                case (op_q)
                    OP_LOAD: begin
                        result_q  <= {pix[1], pix[0]};
                        buffer_q  <= {pix[3], pix[2]};
                        pending_q <= 1'b1;
                    end
                    OP_NEXT: begin
                        result_q  <= pending_q ? buffer_q : 32'd0;
                        pending_q <= 1'b0;
                    end
                    default: begin
                        // CLEAR and the reserved opcode both discard the buffer.
                        result_q  <= 32'd0;
                        buffer_q  <= 32'd0;
                        pending_q <= 1'b0;
                    end
                endcase
            end else if (state_q == ST_DONE) begin
                result_q <= 32'd0;
            end
        end
    end

    assign done   = (state_q == ST_DONE);
    assign result = done ? result_q : 32'd0;

endmodule

// File: tb/tb_gray_rgb565_expand_ise.sv
// Bench for gray_rgb565_expand_ise: directed vector table, multi-cycle corner
// sequences and randomized instructions against an arithmetic reference model.
module tb_gray_rgb565_expand_ise;
    import gray_rgb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    bit          m_pending;
    logic [31:0] m_buf;

    typedef struct {
        logic [7:0]  id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [7:0]  off;
        bit          fires;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[15];

    always #5 clock = ~clock;

    gray_rgb565_expand_ise dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    // Reference pixel: clamp gray+offset to 255, then scale into 5/6/5 fields.
    function automatic logic [15:0] ref_pix(input int g, input int off);
        int s;
        s = g + off;
        if (s > 255) s = 255;
        return 16'((s / 8) * 2048 + (s / 4) * 32 + (s / 8));
    endfunction

    function automatic void model_exec(input logic [7:0] id, input logic [1:0] op,
                                       input logic [31:0] a, input logic [7:0] off,
                                       output bit fires, output logic [31:0] res);
        fires = (id == 8'h0C);
        res   = 32'd0;
        if (fires) begin
            if (op == 2'd0) begin
                res       = {ref_pix(int'(a[15:8]), int'(off)), ref_pix(int'(a[7:0]), int'(off))};
                m_buf     = {ref_pix(int'(a[31:24]), int'(off)), ref_pix(int'(a[23:16]), int'(off))};
                m_pending = 1'b1;
            end else if (op == 2'd1) begin
                res       = m_pending ? m_buf : 32'd0;
                m_pending = 1'b0;
            end else begin
                m_pending = 1'b0;
                m_buf     = 32'd0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction and sample four negedges after the accept edge.
    task automatic run_instr(input logic [7:0] id, input logic [1:0] op,
                             input logic [31:0] a, input logic [7:0] off,
                             output logic [3:0] dpat, output logic [31:0] dres,
                             output bit idle_clean);
        @(negedge clock);
        iseId  = id;
        valueA = a;
        valueB = {16'($urandom), off, 6'($urandom), op};
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        dpat = 4'd0;
        dres = 32'd0;
        idle_clean = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            dpat[i] = done;
            if (done) dres = result;
            else if (result !== 32'd0) idle_clean = 1'b0;
        end
    endtask

    task automatic apply(input string name, input logic [7:0] id, input logic [1:0] op,
                         input logic [31:0] a, input logic [7:0] off,
                         input bit exp_fires, input logic [31:0] exp_res);
        logic [3:0]  dpat;
        logic [31:0] dres;
        bit          clean;
        if (exp_fires) exp_q.push_back(exp_res);
        run_instr(id, op, a, off, dpat, dres, clean);
        check({name, "_done"}, 32'(dpat), exp_fires ? 32'h2 : 32'h0);
        check({name, "_zero_when_idle"}, 32'(clean), 32'd1);
        if (dpat != 4'd0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_unexpected_done: got %h expected none", name, dres);
            end else begin
                check({name, "_result"}, dres, exp_q.pop_front());
            end
        end
        exp_q.delete();
    endtask

    initial begin
        bit          fires;
        logic [31:0] mres;

        vecs[0]  = '{8'h0C, OP_NEXT,  32'h1234_5678, 8'h00, 1'b1, 32'h0000_0000};
        vecs[1]  = '{8'h0C, OP_LOAD,  32'h00FF_8000, 8'h00, 1'b1, 32'h8410_0000};
        vecs[2]  = '{8'h0C, OP_NEXT,  32'h0000_0000, 8'h00, 1'b1, 32'h0000_FFFF};
        vecs[3]  = '{8'h0C, OP_NEXT,  32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000};
        vecs[4]  = '{8'h0C, OP_LOAD,  32'h0000_00F0, 8'h20, 1'b1, 32'h2104_FFFF};
        vecs[5]  = '{8'h0B, OP_NEXT,  32'h0000_0000, 8'h00, 1'b0, 32'h0000_0000};
        vecs[6]  = '{8'h0C, OP_NEXT,  32'hDEAD_BEEF, 8'h55, 1'b1, 32'h2104_2104};
        vecs[7]  = '{8'h0C, OP_LOAD,  32'hFF00_01FF, 8'h00, 1'b1, 32'h0000_FFFF};
        vecs[8]  = '{8'h0C, OP_CLEAR, 32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000};
        vecs[9]  = '{8'h0C, OP_NEXT,  32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000};
        vecs[10] = '{8'h0C, OP_LOAD,  32'h0000_0001, 8'hFF, 1'b1, 32'hFFFF_FFFF};
        vecs[11] = '{8'h0C, 2'd3,     32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000};
        vecs[12] = '{8'h0C, OP_NEXT,  32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000};
        vecs[13] = '{8'h0C, OP_LOAD,  32'h0000_0001, 8'hFF, 1'b1, 32'hFFFF_FFFF};
        vecs[14] = '{8'h0C, OP_NEXT,  32'h0000_0000, 8'h80, 1'b1, 32'hFFFF_FFFF};

        // Clock/reset
        reset = 1'b1; start = 1'b0; iseId = 8'h00; valueA = 32'd0; valueB = 32'd0;
        m_pending = 1'b0; m_buf = 32'd0;
        repeat (3) @(negedge clock);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_done", 32'(done), 32'd0);
        check("post_reset_result", result, 32'd0);

        // Directed table
        for (int v = 0; v < 15; v++) begin
            apply($sformatf("vec%0d", v), vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].off,
                  vecs[v].fires, vecs[v].res);
            model_exec(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].off, fires, mres);
        end

        // Reset during CALC aborts the LOAD and loses the buffer.
        @(negedge clock);
        iseId = 8'h0C; valueA = 32'h00FF_8000; valueB = {16'd0, 8'h00, 8'h00}; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_done_in_reset", 32'(done), 32'd0);
        reset = 1'b0;
        m_pending = 1'b0; m_buf = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("abort_no_done_%0d", i), 32'(done), 32'd0);
        end
        apply("abort_next", 8'h0C, OP_NEXT, 32'd0, 8'd0, 1'b1, 32'd0);
        model_exec(8'h0C, OP_NEXT, 32'd0, 8'd0, fires, mres);

        // Held start: LOAD re-accepted on each IDLE entry, done every 3 cycles.
        @(negedge clock);
        iseId = 8'h0C; valueA = 32'h00FF_8000; valueB = {16'd0, 8'h00, 8'h00}; start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clock);
            if (i == 9) #1 start = 1'b0;
            @(negedge clock);
            check($sformatf("held_done_%0d", i), 32'(done), 32'((i % 3 == 1) && (i <= 10)));
            if (done) check($sformatf("held_result_%0d", i), result, 32'h8410_0000);
        end
        for (int i = 0; i < 4; i++) model_exec(8'h0C, OP_LOAD, 32'h00FF_8000, 8'h00, fires, mres);
        model_exec(8'h0C, OP_NEXT, 32'd0, 8'd0, fires, mres);
        apply("held_next", 8'h0C, OP_NEXT, 32'd0, 8'd0, fires, mres);

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  id;
            logic [1:0]  op;
            logic [31:0] a;
            logic [7:0]  off;
            id  = ($urandom_range(0, 7) == 0) ? 8'h0B : 8'h0C;
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            case ($urandom_range(0, 2))
                0:       off = 8'h00;
                1:       off = 8'hFF;
                default: off = 8'($urandom);
            endcase
            model_exec(id, op, a, off, fires, mres);
            apply($sformatf("rand%0d", n), id, op, a, off, fires, mres);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
